// File: rtl/riscv_pkg.sv
// Shared integer-core definitions: architectural register file geometry and
// the data/index types used by decode and write-back.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/rf_busy_table.sv
// Per-register busy scoreboard: multicycle ops claim a destination at issue
// and release it at write-back; flush drops every outstanding claim.
module rf_busy_table
  import riscv_pkg::*;
#(
  parameter  int NREGS    = riscv_pkg::NREGS,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_idx,
  input  logic             wr_release,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_idx,
  input  logic             flush,
  output logic             claim_ok,
  output logic [NREGS-1:0] busy_vec,
  output logic [AW:0]      busy_cnt
);

  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_cnt;

  logic [NREGS-1:0] w_relMask;
  logic [NREGS-1:0] w_afterRel;
  logic [NREGS-1:0] w_setMask;
  logic             w_zeroClaim;
  logic             w_claimSet;
  logic             w_relDec;

  // A claim only looks at the busy state left after this cycle's release, so
  // a write-back and a re-claim of the same register can share one cycle.
  always_comb begin
    w_relMask = '0;
    if (wr_en && wr_release) w_relMask[wr_idx] = 1'b1;
    w_afterRel  = r_busy & ~w_relMask;
    w_zeroClaim = (ZERO_REG != 0) && (claim_idx == '0);
    claim_ok    = claim_en && !flush && !w_afterRel[claim_idx];
    w_claimSet  = claim_ok && !w_zeroClaim;
    w_setMask   = '0;
    if (w_claimSet) w_setMask[claim_idx] = 1'b1;
    w_relDec    = wr_en && wr_release && r_busy[wr_idx];
  end

  // The count only moves on real bit transitions, so it tracks popcount exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_afterRel | w_setMask;
      r_cnt  <= r_cnt + {{AW{1'b0}}, w_claimSet} - {{AW{1'b0}}, w_relDec};
    end
  end

  assign busy_vec = r_busy;
  assign busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with NRD combinational read ports, one write port,
// optional write->read bypass and a busy scoreboard for multicycle results.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter  int XLEN     = riscv_pkg::XLEN,
  parameter  int NREGS    = riscv_pkg::NREGS,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_idx,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              wr_release,
  input  logic              claim_en,
  input  logic [AW-1:0]     claim_idx,
  output logic              claim_ok,
  input  logic              flush,
  output logic [NREGS-1:0]  busy_vec,
  output logic [AW:0]       busy_cnt
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wrAllowed;

  assign w_wrAllowed = wr_en && !((ZERO_REG != 0) && (wr_idx == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wrAllowed) begin
      r_regs[wr_idx] <= wr_data;
    end
  end

  // Register 0 is never claimed in ZERO_REG mode, so its busy bit is always 0.
  for (genvar p = 0; p < NRD; p++) begin : gRead
    logic [AW-1:0]   w_idx;
    logic            w_isZero;
    logic            w_hit;
    logic [XLEN-1:0] w_data;

    assign w_idx    = rd_idx[p*AW +: AW];
    assign w_isZero = (ZERO_REG != 0) && (w_idx == '0);
    assign w_hit    = (BYPASS != 0) && wr_en && (wr_idx == w_idx);
    assign w_data   = w_isZero ? '0 : (w_hit ? wr_data : r_regs[w_idx]);
    assign rd_data[p*XLEN +: XLEN] = w_data;
    assign rd_busy[p] = busy_vec[w_idx];
  end

  rf_busy_table #(
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG)
  ) uBusy (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_release(wr_release),
    .claim_en  (claim_en),
    .claim_idx (claim_idx),
    .flush     (flush),
    .claim_ok  (claim_ok),
    .busy_vec  (busy_vec),
    .busy_cnt  (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios with literal expectations
// plus a random phase, all checked every cycle against an array-based model.
module tb_regfile_scoreboard;
  import riscv_pkg::*;

  localparam int W  = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int A  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NP*A-1:0]   rd_idx = '0;
  logic [NP*W-1:0]   rd_data;
  logic [NP-1:0]     rd_busy;
  logic              wr_en = 1'b0;
  logic [A-1:0]      wr_idx = '0;
  logic [W-1:0]      wr_data = '0;
  logic              wr_release = 1'b0;
  logic              claim_en = 1'b0;
  logic [A-1:0]      claim_idx = '0;
  logic              claim_ok;
  logic              flush = 1'b0;
  logic [NR-1:0]     busy_vec;
  logic [A:0]        busy_cnt;

  int total = 0;
  int bad   = 0;

  xlen_t modelRegs [NR];
  bit    modelBusy [NR];

  regfile_scoreboard #(
    .XLEN(W), .NREGS(NR), .NRD(NP), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_release(wr_release),
    .claim_en(claim_en), .claim_idx(claim_idx), .claim_ok(claim_ok),
    .flush(flush), .busy_vec(busy_vec), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] expRead(input int idx);
    if (idx == 0) return '0;
    if (wr_en && int'(wr_idx) == idx) return wr_data;
    return modelRegs[idx];
  endfunction

  function automatic bit expClaimOk();
    bit freeAfterRelease;
    freeAfterRelease = !modelBusy[claim_idx] || (wr_en && wr_release && wr_idx == claim_idx);
    return claim_en && !flush && freeAfterRelease;
  endfunction

  function automatic int expCount();
    int n = 0;
    for (int i = 0; i < NR; i++) n += modelBusy[i];
    return n;
  endfunction

  function automatic logic [NR-1:0] expBusyVec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = modelBusy[i];
    return v;
  endfunction

  // Reference behaviour: asynchronous clear, then per-edge rules.
  always @(negedge rst) begin
    for (int i = 0; i < NR; i++) begin
      modelRegs[i] = '0;
      modelBusy[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      bit ok;
      ok = expClaimOk();
      if (flush) begin
        for (int i = 0; i < NR; i++) modelBusy[i] = 1'b0;
      end else begin
        if (wr_en && wr_release) modelBusy[wr_idx] = 1'b0;
        if (ok && claim_idx != 0) modelBusy[claim_idx] = 1'b1;
      end
      if (wr_en && wr_idx != 0) modelRegs[wr_idx] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        int idx;
        idx = int'(rd_idx[p*A +: A]);
        checkOutput("rdData", 64'(rd_data[p*W +: W]), 64'(expRead(idx)));
        checkOutput("rdBusy", 64'(rd_busy[p]), 64'(modelBusy[idx]));
      end
      checkOutput("claimOk", 64'(claim_ok), 64'(expClaimOk()));
      checkOutput("busyVec", 64'(busy_vec), 64'(expBusyVec()));
      checkOutput("busyCnt", 64'(busy_cnt), 64'(expCount()));
      checkOutput("cntPop", 64'(busy_cnt), 64'($countones(busy_vec)));
    end
  end

  task automatic applyStimulus(input bit we, input int wi, input logic [W-1:0] wd, input bit rel,
                               input bit ce, input int ci, input bit fl, input int r0, input int r1);
    wr_en = we; wr_idx = A'(wi); wr_data = wd; wr_release = rel;
    claim_en = ce; claim_idx = A'(ci); flush = fl;
    rd_idx[0 +: A] = A'(r0);
    rd_idx[A +: A] = A'(r1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst = 1'b1;
    step();

    // Write with same-cycle bypass, then stored value; x0 stays zero.
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0);
    #1 checkOutput("bypassX5", 64'(rd_data[W-1:0]), 64'hDEADBEEF);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
    #1 checkOutput("storedX5", 64'(rd_data[W-1:0]), 64'hDEADBEEF);
    step();
    applyStimulus(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("x0Bypass", 64'(rd_data[W-1:0]), 64'h0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("x0Stored", 64'(rd_data[W-1:0]), 64'h0);
    step();

    // Claim then WAW stall on the same register.
    applyStimulus(0, 0, 0, 0, 1, 7, 0, 0, 7);
    #1 checkOutput("claim7Ok", 64'(claim_ok), 64'h1);
    step();
    #1 checkOutput("claim7Stall", 64'(claim_ok), 64'h0);
    checkOutput("cntAfterClaim", 64'(busy_cnt), 64'h1);
    checkOutput("rdBusy1", 64'(rd_busy[1]), 64'h1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7);
    #1 checkOutput("cntStall", 64'(busy_cnt), 64'h1);
    step();

    // Release and re-claim x7 in one cycle.
    applyStimulus(1, 7, 32'h55, 1, 1, 7, 0, 7, 7);
    #1 checkOutput("relClaimOk", 64'(claim_ok), 64'h1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 7);
    #1 checkOutput("x7StillBusy", 64'(busy_vec[7]), 64'h1);
    checkOutput("cntRelClaim", 64'(busy_cnt), 64'h1);
    checkOutput("x7Data", 64'(rd_data[W-1:0]), 64'h55);
    step();

    // Release x7, claim x1..x3, then flush with a competing claim.
    applyStimulus(1, 7, 32'h55, 1, 0, 0, 0, 5, 0);
    step();
    for (int r = 1; r <= 3; r++) begin
      applyStimulus(0, 0, 0, 0, 1, r, 0, 5, r);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
    #1 checkOutput("cntThree", 64'(busy_cnt), 64'h3);
    applyStimulus(0, 0, 0, 0, 1, 4, 1, 5, 4);
    #1 checkOutput("flushClaim", 64'(claim_ok), 64'h0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 7);
    #1 checkOutput("flushVec", 64'(busy_vec), 64'h0);
    checkOutput("flushCnt", 64'(busy_cnt), 64'h0);
    checkOutput("flushData", 64'(rd_data[W-1:0]), 64'hDEADBEEF);
    checkOutput("flushDataX7", 64'(rd_data[2*W-1:W]), 64'h55);
    step();

    // Asynchronous reset mid-cycle with state present.
    applyStimulus(0, 0, 0, 0, 1, 9, 0, 5, 7);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 7);
    #2 rst = 1'b0;
    #1 checkOutput("rstData0", 64'(rd_data[W-1:0]), 64'h0);
    checkOutput("rstData1", 64'(rd_data[2*W-1:W]), 64'h0);
    checkOutput("rstVec", 64'(busy_vec), 64'h0);
    checkOutput("rstCnt", 64'(busy_cnt), 64'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    step();

    // Random traffic, indices biased to a small window for collisions.
    for (int c = 0; c < 10000; c++) begin
      int wi, ci, r0, r1;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      wi = narrow ? $urandom_range(0, 7) : $urandom_range(0, NR - 1);
      ci = narrow ? $urandom_range(0, 7) : $urandom_range(0, NR - 1);
      r0 = narrow ? $urandom_range(0, 7) : $urandom_range(0, NR - 1);
      r1 = $urandom_range(0, NR - 1);
      applyStimulus($urandom_range(0, 1), wi, $urandom, $urandom_range(0, 1),
                    $urandom_range(0, 1), ci, ($urandom_range(0, 31) == 0), r0, r1);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
